// File: rtl/mdu_pkg.sv
// Shared constants and decode helpers for the iterative multiply/divide sequencer.
// Pure declarations: no latency or flow control of its own.
// The zero-operand shortcut is selected with MDU_ZERO_SKIP_EN in mdu_special_detect.
package mdu_pkg;

    localparam int MDU_XLEN = 64;

    typedef logic [2:0] mdu_op_t;

    localparam mdu_op_t MDU_MUL    = 3'd0;
    localparam mdu_op_t MDU_MULH   = 3'd1;
    localparam mdu_op_t MDU_MULHSU = 3'd2;
    localparam mdu_op_t MDU_MULHU  = 3'd3;
    localparam mdu_op_t MDU_DIV    = 3'd4;
    localparam mdu_op_t MDU_DIVU   = 3'd5;
    localparam mdu_op_t MDU_REM    = 3'd6;
    localparam mdu_op_t MDU_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic logic is_div(input mdu_op_t op);
        return op[2];
    endfunction

    // MUL is treated as signed: its low half does not depend on operand signedness.
    function automatic logic is_signed_rs1(input mdu_op_t op);
        return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
    endfunction

    function automatic logic is_signed_rs2(input mdu_op_t op);
        return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between decode/ex and the multiply/divide sequencer.
// No latency of its own; req_valid/req_ready handshake, stall held while busy.
// master = execute stage, slave = mdu_seq.
interface mdu_seq_if
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
);
    logic            req_valid;
    logic            req_ready;
    mdu_op_t         op;
    logic [XLEN-1:0] oprand1;
    logic [XLEN-1:0] oprand2;
    logic            flush;
    logic            resp_valid;
    logic [XLEN-1:0] result;
    logic            stall;

    modport master (
        output req_valid, op, oprand1, oprand2, flush,
        input  req_ready, resp_valid, result, stall
    );

    modport slave (
        input  req_valid, op, oprand1, oprand2, flush,
        output req_ready, resp_valid, result, stall
    );
endinterface

// File: rtl/mdu_special_detect.sv
// Flags operations that finish without iterating and forms their result.
// Latency: combinational. Backpressure: none, evaluated on the IDLE request.
// MDU_ZERO_SKIP_EN adds the zero-operand shortcut for MUL and DIV families.
module mdu_special_detect
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  mdu_op_t         op_i,
    input  logic [XLEN-1:0] oprand1_i,
    input  logic [XLEN-1:0] oprand2_i,
    output logic            special_o,
    output logic [XLEN-1:0] special_result_o
);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic div_zero;
    logic sgn_ovf;
    logic zero_skip;

    always_comb begin
        div_zero = is_div(op_i) && (oprand2_i == '0);
        sgn_ovf  = is_div(op_i) && is_signed_rs1(op_i)
                   && (oprand1_i == MOST_NEG) && (oprand2_i == '1);
`ifdef MDU_ZERO_SKIP_EN
        if (is_div(op_i)) begin
            zero_skip = (oprand1_i == '0) && (oprand2_i != '0);
        end else begin
            zero_skip = (oprand1_i == '0) || (oprand2_i == '0);
        end
`else
        zero_skip = 1'b0;
`endif
        special_o = div_zero || sgn_ovf || zero_skip;

        // op[1] separates REM/REMU from DIV/DIVU within the divide family.
        special_result_o = '0;
        if (div_zero) begin
            special_result_o = op_i[1] ? oprand1_i : '1;
        end else if (sgn_ovf) begin
            special_result_o = op_i[1] ? '0 : oprand1_i;
        end
    end
endmodule

// File: rtl/mdu_seq.sv
// Radix-2 multiply/divide sequencer: shift-add / restoring shift-subtract, then sign fix-up.
// Latency: XLEN+2 cycles from accept to resp_valid; special cases 1 cycle.
// Backpressure: req_ready only in IDLE, stall held through CALC/FIX. Optional: MDU_ZERO_SKIP_EN.
module mdu_seq
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic     clk,
    input  logic     rst,
    mdu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    mdu_op_t           op_q, op_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              special;
    logic [XLEN-1:0]   special_result;
    logic              sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    mdu_special_detect #(.XLEN(XLEN)) u_special (
        .op_i             (bus.op),
        .oprand1_i        (bus.oprand1),
        .oprand2_i        (bus.oprand2),
        .special_o        (special),
        .special_result_o (special_result)
    );

    assign accept = (state_q == ST_IDLE) && bus.req_valid && !bus.flush;

    always_comb begin
        sign1 = is_signed_rs1(bus.op) && bus.oprand1[XLEN-1];
        sign2 = is_signed_rs2(bus.op) && bus.oprand2[XLEN-1];
        mag1  = sign1 ? -bus.oprand1 : bus.oprand1;
        mag2  = sign2 ? -bus.oprand2 : bus.oprand2;
    end

    // acc_q is shared: {product high, multiplier/product low} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = {div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0],
                     acc_q[XLEN-2:0], ~div_diff[XLEN]};
    end

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MDU_MUL:                        fix_result = prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              fix_result = quo_fix;
            default:                        fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = bus.op;
                    if (special) begin
                        result_d = special_result;
                        state_d  = ST_DONE;
                    end else begin
                        neg_res_d = sign1 ^ sign2;
                        neg_rem_d = sign1;
                        cnt_d     = '0;
                        if (is_div(bus.op)) begin
                            acc_d  = {{XLEN{1'b0}}, mag1};
                            opnd_d = mag2;
                        end else begin
                            acc_d  = {{XLEN{1'b0}}, mag2};
                            opnd_d = mag1;
                        end
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = fix_result;
                state_d  = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A flush kills the operation outright and must not disturb the held result.
        if (bus.flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MDU_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_DONE) && !bus.flush;
    assign bus.result     = result_q;
    assign bus.stall      = accept || (state_q == ST_CALC) || (state_q == ST_FIX);

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: latency, results, stall, flush, reset and no-back-to-back behaviour.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.XLEN(64)) bus ();

    mdu_seq #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef MDU_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 66;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, measure cycles to resp_valid, check result and the pulse width.
    task automatic do_op(input string tag, input mdu_op_t o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int   lat;
        logic st_ok;
        bus.op        = o;
        bus.oprand1   = a;
        bus.oprand2   = b;
        bus.req_valid = 1'b1;
        #1;
        check({tag, " ready"}, 64'(bus.req_ready), 64'd1);
        st_ok = bus.stall;
        lat   = 0;
        do begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            #1;
            lat++;
            if (!bus.resp_valid) st_ok &= bus.stall;
        end while (!bus.resp_valid && lat < 300);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, bus.result, exp);
        check({tag, " stall busy"}, 64'(st_ok), 64'd1);
        check({tag, " stall done"}, 64'(bus.stall), 64'd0);
        check({tag, " ready done"}, 64'(bus.req_ready), 64'd0);
        step();
        check({tag, " pulse"}, 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.op        = MDU_MUL;
        bus.oprand1   = '0;
        bus.oprand2   = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst result", bus.result, 64'd0);
        check("rst stall", 64'(bus.stall), 64'd0);
        check("rst ready", 64'(bus.req_ready), 64'd1);
        step();

        do_op("divu 100/7", MDU_DIVU, 64'd100, 64'd7, 64'd14, 66);
        do_op("rem -7/2", MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        do_op("div -7/2", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        do_op("div 5/0", MDU_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        do_op("remu 5/0", MDU_REMU, 64'd5, 64'd0, 64'd5, 1);
        do_op("div ovf", MDU_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1);
        do_op("rem ovf", MDU_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        do_op("mulh -1*-1", MDU_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66);
        do_op("mulhu -1*-1", MDU_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 66);
        do_op("mulhsu -1*2", MDU_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        do_op("mulhsu 2*max", MDU_MULHSU, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 66);
        do_op("remu 100/7", MDU_REMU, 64'd100, 64'd7, 64'd2, 66);
        do_op("mul 0*x", MDU_MUL, 64'd0, 64'd12345, 64'd0, ZLAT);
        do_op("mul 3*-4", MDU_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4, 66);

        // Flush in CALC cycle 10: nothing returned, result keeps the previous value.
        bus.op        = MDU_DIVU;
        bus.oprand1   = 64'd100;
        bus.oprand2   = 64'd7;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c < 10; c++) step();
        bus.flush = 1'b1;
        #1;
        check("flush calc resp", 64'(bus.resp_valid), 64'd0);
        check("flush calc stall", 64'(bus.stall), 64'd1);
        step();
        bus.flush = 1'b0;
        #1;
        check("flush idle ready", 64'(bus.req_ready), 64'd1);
        check("flush idle stall", 64'(bus.stall), 64'd0);
        check("flush idle resp", 64'(bus.resp_valid), 64'd0);
        check("flush result kept", bus.result, 64'hFFFF_FFFF_FFFF_FFF4);
        do_op("divu 9/3 after flush", MDU_DIVU, 64'd9, 64'd3, 64'd3, 66);

        // Flush together with a request in IDLE drops the request.
        bus.op        = MDU_DIVU;
        bus.oprand1   = 64'd50;
        bus.oprand2   = 64'd5;
        bus.req_valid = 1'b1;
        bus.flush     = 1'b1;
        #1;
        check("flush+req stall", 64'(bus.stall), 64'd0);
        step();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        seen          = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (bus.resp_valid) seen++;
        end
        check("flush+req no resp", 64'(seen), 64'd0);
        check("flush+req result", bus.result, 64'd3);

        // Request held through DONE waits for the following IDLE cycle.
        bus.op        = MDU_DIV;
        bus.oprand1   = 64'd5;
        bus.oprand2   = 64'd0;
        bus.req_valid = 1'b1;
        step();
        bus.op = MDU_REMU;
        #1;
        check("b2b done resp", 64'(bus.resp_valid), 64'd1);
        check("b2b done ready", 64'(bus.req_ready), 64'd0);
        check("b2b done stall", 64'(bus.stall), 64'd0);
        check("b2b done result", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("b2b idle ready", 64'(bus.req_ready), 64'd1);
        check("b2b idle stall", 64'(bus.stall), 64'd1);
        check("b2b idle resp", 64'(bus.resp_valid), 64'd0);
        step();
        bus.req_valid = 1'b0;
        #1;
        check("b2b second resp", 64'(bus.resp_valid), 64'd1);
        check("b2b second result", bus.result, 64'd5);
        step();

        // Reset while in FIX abandons the operation.
        bus.op        = MDU_DIVU;
        bus.oprand1   = 64'd100;
        bus.oprand2   = 64'd7;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        for (int c = 1; c < 65; c++) step();
        #1;
        check("fix stall", 64'(bus.stall), 64'd1);
        check("fix ready", 64'(bus.req_ready), 64'd0);
        check("fix resp", 64'(bus.resp_valid), 64'd0);
        rst = 1'b1;
        step();
        check("rst fix resp", 64'(bus.resp_valid), 64'd0);
        check("rst fix result", bus.result, 64'd0);
        check("rst fix stall", 64'(bus.stall), 64'd0);
        rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 70; c++) begin
            step();
            if (bus.resp_valid) seen++;
        end
        check("rst fix no resp", 64'(seen), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Sequencer for the shared iterative radix-2 multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one RV64M operation per handshake and runs the shift-add or shift-subtract datapath for XLEN iterations.
- Applies the sign fix-up, returns a one-cycle result pulse, and drives the execute-stage stall while busy.
- Resolves RISC-V divide special cases without iterating.

Parameters:
XLEN, 64, operand/result width; iteration count equals XLEN

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
req_valid  in  1  operation request from decode/ex
req_ready  out  1  high only in IDLE
op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
oprand1  in  XLEN  rs1 value
oprand2  in  XLEN  rs2 value
flush  in  1  kill in-flight operation (branch/trap)
resp_valid  out  1  one-cycle pulse, result valid
result  out  XLEN  operation result, held until next accept
stall  out  1  execute-stage stall request

Behaviour:
- Reset: state IDLE; resp_valid=0, result=0, stall=0, internal accumulators/counter cleared. Reset mid-operation abandons it with no resp_valid.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - req_ready=1. Accept on req_valid && !flush.
  - Special case (div/rem with oprand2==0, or signed DIV/REM with oprand1=-2^(XLEN-1) and oprand2=-1) -> DONE directly.
  - Otherwise latch operand magnitudes and sign flags, counter=0 -> CALC.
- CALC:
  - One iteration per cycle; counter increments; exits to FIX when counter==XLEN-1.
  - MUL: 2*XLEN-bit product register, shift-add on unsigned magnitudes.
  - DIV: restoring shift-subtract; quotient and remainder registers.
- FIX:
  - Negate product if operand signs differ (MULH: both signed; MULHSU: rs1 signed only).
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select low half (MUL) or high half (MULH*). Load result -> DONE.
- DONE: resp_valid=1 for exactly one cycle; req_ready=0; -> IDLE.
- Special-case results:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = oprand1.
  - Signed overflow: quotient = oprand1; remainder = 0.
- Latency:
  - Normal path: accept in cycle 0, CALC cycles 1..XLEN, FIX cycle XLEN+1, resp_valid in cycle XLEN+2.
  - Special case: resp_valid in cycle 1.
- Stall:
  - Combinational: high when (IDLE && req_valid && !flush), or in CALC, or in FIX.
  - Low in DONE, so ex captures result while the pipeline advances.
- Flush:
  - In any state, next state is IDLE with no resp_valid; result register is unchanged.
  - Flush with req_valid in IDLE: request dropped; flush wins over a simultaneous accept.
- No back-to-back: a request presented in DONE waits; ready rises in the following IDLE cycle.

Optional Feature:
MDU_ZERO_SKIP_EN
- Defined: an IDLE accept of a MUL-family op with either operand zero goes directly to DONE with result 0 (latency 1). A DIV/DIVU/REM/REMU with oprand1==0 and nonzero divisor goes directly to DONE with result 0 (latency 1).
- Undefined: these cases take the full XLEN+2 latency with identical results.

Decomposition:
- Package mdu_pkg holds:
  - XLEN default
  - 3-bit op encodings (MDU_MUL..MDU_REMU)
  - state encoding (IDLE/CALC/FIX/DONE)
  - helpers is_div(op) and is_signed_rs1/rs2(op)
- One sub-module, mdu_special_detect (combinational): flags div-by-zero, signed overflow and (under the macro) zero-skip, and forms the special result.

Test Plan:
- DIVU oprand1=100, oprand2=7 -> resp_valid exactly 66 cycles after accept, result=14; stall high cycles 0..65, low in cycle 66.
- REM oprand1=-7, oprand2=2 -> result=-1; DIV same operands -> result=-3.
- DIV oprand2=0, oprand1=5 -> result=0xFFFF_FFFF_FFFF_FFFF in cycle 1. REMU same -> 5. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000.
- MULH oprand1=-1, oprand2=-1 -> 0; MULHU same -> 0xFFFF_FFFF_FFFF_FFFE; MUL 3*-4 -> -12.
- flush asserted in CALC cycle 10 -> no resp_valid, IDLE next cycle, req_ready=1. A new DIVU 9/3 then yields 3.
- rst asserted in FIX -> all outputs 0 next cycle. With MDU_ZERO_SKIP_EN: MUL 0*x -> result 0 in cycle 1.
